// File: rtl/baw_btn_conditioner_pkg.sv
// Shared definitions for the push-button front end of the Black-and-White game:
// button index map, channel state encoding and a small state-decode helper.
package baw_btn_conditioner_pkg;

  localparam int N_BTN_DEF  = 5;
  localparam int BTN_CENTER = 0;
  localparam int BTN_TOP    = 1;
  localparam int BTN_BOTTOM = 2;
  localparam int BTN_LEFT   = 3;
  localparam int BTN_RIGHT  = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMING    = 2'd1,
    ST_HELD      = 2'd2,
    ST_RELEASING = 2'd3
  } ch_state_t;

  // The debounced level stays high through the release-debounce window.
  function automatic logic ch_level(input ch_state_t st);
    return (st == ST_HELD) || (st == ST_RELEASING);
  endfunction

endpackage

// File: rtl/baw_btn_conditioner_debounce_ch.sv
// One button channel: 2-flop synchroniser, debounce counter, press FSM and a
// pending bit that holds the press until the arbiter grants it.
module baw_debounce_ch
  import baw_btn_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int CNT_W        = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic clr_pend,
  output logic pend,
  output logic level
);

  if (DEBOUNCE_CYC < 2) begin : g_bad_cyc
    $error("DEBOUNCE_CYC must be at least 2");
  end
  if ((2 ** CNT_W) <= DEBOUNCE_CYC) begin : g_bad_w
    $error("CNT_W too narrow for DEBOUNCE_CYC");
  end

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYC - 1);

  logic [1:0]       sync_reg;
  ch_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             pend_reg, pend_next;
  logic             set_pend;
  logic             s;

  assign s = sync_reg[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg  <= 2'b00;
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      pend_reg  <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[0], raw};
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pend_reg  <= pend_next;
    end
  end

  // Every state exit reloads the counter, so it is bounded by CNT_TERM.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    set_pend   = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (s) begin
          state_next = ST_ARMING;
          cnt_next   = CNT_ONE;
        end
      end
      ST_ARMING: begin
        if (!s) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_TERM) begin
          state_next = ST_HELD;
          cnt_next   = '0;
          set_pend   = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      ST_HELD: begin
        if (!s) begin
          state_next = ST_RELEASING;
          cnt_next   = CNT_ONE;
        end
      end
      ST_RELEASING: begin
        if (s) begin
          state_next = ST_HELD;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_TERM) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // A press survives an early release until it has been granted.
  assign pend_next = (pend_reg & ~clr_pend) | set_pend;

  assign pend  = pend_reg;
  assign level = ch_level(state_reg);

endmodule

// File: rtl/baw_btn_conditioner.sv
// Button conditioner top: N_BTN debounce channels, a lowest-index-first arbiter
// and a registered one-hot press pulse for the game FSM.
module baw_btn_conditioner
  import baw_btn_conditioner_pkg::*;
#(
  parameter int N_BTN        = N_BTN_DEF,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int CNT_W        = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_BTN-1:0] btn_level
);

  logic [N_BTN-1:0] pend;
  logic [N_BTN-1:0] grant;
  logic [N_BTN-1:0] pulse_reg, pulse_next;

  genvar gi;
  generate
    for (gi = 0; gi < N_BTN; gi++) begin : g_ch
      baw_debounce_ch #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC),
        .CNT_W       (CNT_W)
      ) u_ch (
        .clk     (clk),
        .rst     (rst),
        .raw     (btn_raw[gi]),
        .clr_pend(grant[gi]),
        .pend    (pend[gi]),
        .level   (btn_level[gi])
      );
    end
  endgenerate

  // Isolate the lowest set pending bit; the others wait for later cycles.
  assign grant      = pend & (~pend + N_BTN'(1));
  assign pulse_next = grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_reg <= '0;
    end else begin
      pulse_reg <= pulse_next;
    end
  end

  assign btn_pulse = pulse_reg;

endmodule
